ft_cell_selector: RTL and testbench
===================================

Name: ft_cell_selector

Overview:
- Consumes the once-per-frame fingertip coordinate strobe from the fingertip detector: iFT_X, iFT_Y, and a one-cycle iFT_VAL pulse at end of frame.
- Maps each coordinate to one of nine 3x3 tic-tac-toe grid cells.
- Requires the fingertip to dwell in one cell for DWELL_FRAMES consecutive frames, then issues a move to the game logic with a valid/ack handshake.
- After a move, holds off the next move until the fingertip releases the committed cell.

Parameters:
- SCREEN_WIDTH, 640, x at or above this value means no fingertip.
- SCREEN_HEIGHT, 480, y at or above this value means no fingertip.
- COL_B1, 213, first column boundary; x < COL_B1 is column 0.
- COL_B2, 426, second column boundary; COL_B1 <= x < COL_B2 is column 1, otherwise column 2.
- ROW_B1, 160, first row boundary, same rule applied to y.
- ROW_B2, 320, second row boundary, same rule applied to y.
- DWELL_FRAMES, 8, consecutive same-cell frames required to commit a move (>=1).
- RELEASE_FRAMES, 4, consecutive off-cell frames required to re-arm (>=1).

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous, active-low reset.
- iEN  in  1  selector enable; low forces IDLE and ignores frames.
- iFT_X  in  10  fingertip x, qualified by iFT_VAL.
- iFT_Y  in  10  fingertip y, qualified by iFT_VAL.
- iFT_VAL  in  1  one-cycle pulse, one per frame.
- iMOVE_ACK  in  1  game logic accepts the pending move.
- oMOVE_VALID  out  1  move pending; held until acked.
- oMOVE_CELL  out  4  committed cell 0..8 (row*3+col); stable while oMOVE_VALID is high.
- oHOVER_CELL  out  4  cell of the last frame; 4'hF when no fingertip.
- oHOVER_VALID  out  1  last frame had a valid fingertip.
- oDWELL_CNT  out  4  current dwell count, saturating at 15; for on-screen progress display.

Behaviour:
- Reset (iRST low, asynchronous):
  - State IDLE.
  - oMOVE_VALID=0, oMOVE_CELL=0, oHOVER_CELL=4'hF, oHOVER_VALID=0, oDWELL_CNT=0.
  - Internal dwell count, release count and candidate cell cleared.
- Stage 1 (mapping register), updated only on cycles where iFT_VAL=1:
  - pos_ok = (iFT_X < SCREEN_WIDTH) && (iFT_Y < SCREEN_HEIGHT).
  - cell = row*3+col per the boundary parameters; 4'hF when !pos_ok.
  - oHOVER_CELL and oHOVER_VALID are driven from this register, so they update 1 cycle after iFT_VAL.
  - A one-cycle frame_tick is registered alongside.
- Stage 2 (FSM) acts on frame_tick, so FSM outputs change 2 cycles after the iFT_VAL sample.
- IDLE:
  - Valid cell -> cand=cell, cnt=1.
  - If DWELL_FRAMES==1 -> HOLD; otherwise -> TRACK.
  - Invalid cell -> remain in IDLE.
- TRACK:
  - Same valid cell -> cnt+1. When cnt+1==DWELL_FRAMES -> HOLD, oMOVE_CELL=cand, oMOVE_VALID=1.
  - Different valid cell -> cand=new cell, cnt=1, stay in TRACK.
  - Invalid -> IDLE, cnt=0.
- HOLD:
  - oMOVE_VALID stays high and oMOVE_CELL stays constant.
  - Frames are ignored (hover outputs still update).
  - iMOVE_ACK sampled high -> oMOVE_VALID=0 on the next edge, rel=0, -> LOCKOUT.
  - If the ack and frame_tick occur in the same cycle, the ack wins and the frame is discarded.
- LOCKOUT:
  - Frame with invalid position or cell != oMOVE_CELL -> rel+1. When rel+1==RELEASE_FRAMES -> IDLE, cnt=0.
  - Frame in the committed cell -> rel=0.
  - The frame that completes the release is not counted as a dwell frame.
- iEN low: synchronous return to IDLE with cnt=0 and rel=0 from any state.
  - A pending oMOVE_VALID is dropped, not acked.
- oDWELL_CNT = cnt, saturating at 15; it is 0 in IDLE and LOCKOUT and holds DWELL_FRAMES in HOLD.
- iMOVE_ACK outside HOLD has no effect.
- iFT_VAL held high for several cycles counts as one frame per cycle; the upstream detector guarantees a one-cycle pulse.
- Boundary rules:
  - x=COL_B1 maps to column 1.
  - x=SCREEN_WIDTH-1 maps to column 2.
  - x=SCREEN_WIDTH is invalid.
  - The same rules apply to rows.

Test Plan:
- Reset, then DWELL_FRAMES=8 frames at (300,200) -> oHOVER_CELL=4 one cycle after the first iFT_VAL; oMOVE_VALID rises 2 cycles after the 8th iFT_VAL with oMOVE_CELL=4; no earlier assertion.
- 5 frames at (100,100), then 1 frame at (500,400), then 7 frames at (500,400) -> the candidate switches at the change; move with oMOVE_CELL=8 after the 8th cell-8 frame; oDWELL_CNT shows 5, then 1.
- In HOLD, keep iMOVE_ACK low for 20 frames -> oMOVE_VALID stays 1 and oMOVE_CELL stays constant. Pulse the ack coincident with iFT_VAL -> oMOVE_VALID=0 next cycle, state LOCKOUT, frame discarded.
- In LOCKOUT on cell 4: 3 frames at (1023,1023), 1 frame back in cell 4, then 4 invalid frames -> re-arm only after the final 4th consecutive frame. Then 8 cell-4 frames -> second move.
- Boundaries: x=212/213/425/426/639/640 with y=0 -> cells 0/1/1/2/2/F. Same sweep on y=159/160/319/320/479/480 with x=0 -> cells 0/3/3/6/6/F.
- Assert iRST mid-TRACK (cnt=6) and separately in HOLD -> all outputs at reset values asynchronously. Drop iEN in HOLD -> oMOVE_VALID=0 next edge, state IDLE.

Source files
------------

// File: rtl/ft_cell_selector.sv
// Fingertip-to-grid move selector: maps per-frame fingertip coordinates onto a 3x3 board,
// commits a move after a dwell period and waits for the finger to leave before re-arming.
module ft_cell_selector #(
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int COL_B1         = 213,
  parameter int COL_B2         = 426,
  parameter int ROW_B1         = 160,
  parameter int ROW_B2         = 320,
  parameter int DWELL_FRAMES   = 8,
  parameter int RELEASE_FRAMES = 4
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iEN,
  input  logic [9:0] iFT_X,
  input  logic [9:0] iFT_Y,
  input  logic       iFT_VAL,
  input  logic       iMOVE_ACK,
  output logic       oMOVE_VALID,
  output logic [3:0] oMOVE_CELL,
  output logic [3:0] oHOVER_CELL,
  output logic       oHOVER_VALID,
  output logic [3:0] oDWELL_CNT,
  output logic [1:0] oSTATE
);

  // Move handshake: oMOVE_VALID rises with oMOVE_CELL stable and stays high until a cycle
  // where iMOVE_ACK is sampled high; the move transfers on that edge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    HOLD    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [9:0] SCR_W_C = 10'(SCREEN_WIDTH);
  localparam logic [9:0] SCR_H_C = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] COL1_C  = 10'(COL_B1);
  localparam logic [9:0] COL2_C  = 10'(COL_B2);
  localparam logic [9:0] ROW1_C  = 10'(ROW_B1);
  localparam logic [9:0] ROW2_C  = 10'(ROW_B2);
  localparam logic [7:0] DWELL_C = 8'(DWELL_FRAMES);
  localparam logic [7:0] REL_C   = 8'(RELEASE_FRAMES);

  logic [1:0] col, row;
  logic       pos_ok;
  logic [3:0] map_cell;

  logic [3:0] hover_cell_q;
  logic       hover_valid_q;
  logic       tick_q;

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rel_q, rel_d;
  logic       move_valid_q, move_valid_d;
  logic [3:0] move_cell_q, move_cell_d;

  always_comb begin
    col = 2'd2;
    if (iFT_X < COL1_C)      col = 2'd0;
    else if (iFT_X < COL2_C) col = 2'd1;
    row = 2'd2;
    if (iFT_Y < ROW1_C)      row = 2'd0;
    else if (iFT_Y < ROW2_C) row = 2'd1;
    pos_ok   = (iFT_X < SCR_W_C) && (iFT_Y < SCR_H_C);
    map_cell = pos_ok ? ({2'b00, row} * 4'd3 + {2'b00, col}) : 4'hF;
  end

  // Mapping stage: hover outputs and the frame tick lead the FSM by one cycle.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      hover_cell_q  <= 4'hF;
      hover_valid_q <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      tick_q <= iFT_VAL;
      if (iFT_VAL) begin
        hover_cell_q  <= map_cell;
        hover_valid_q <= pos_ok;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q      <= IDLE;
      cand_q       <= 4'd0;
      cnt_q        <= 8'd0;
      rel_q        <= 8'd0;
      move_valid_q <= 1'b0;
      move_cell_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      rel_q        <= rel_d;
      move_valid_q <= move_valid_d;
      move_cell_q  <= move_cell_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    rel_d        = rel_q;
    move_valid_d = move_valid_q;
    move_cell_d  = move_cell_q;
    if (!iEN) begin
      state_d      = IDLE;
      cnt_d        = 8'd0;
      rel_d        = 8'd0;
      move_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick_q && hover_valid_q) begin
            cand_d = hover_cell_q;
            cnt_d  = 8'd1;
            if (DWELL_C == 8'd1) begin
              state_d      = HOLD;
              move_valid_d = 1'b1;
              move_cell_d  = hover_cell_q;
            end else begin
              state_d = TRACK;
            end
          end
        end
        TRACK: begin
          if (tick_q) begin
            if (!hover_valid_q) begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end else if (hover_cell_q == cand_q) begin
              cnt_d = cnt_q + 8'd1;
              if (cnt_q + 8'd1 == DWELL_C) begin
                state_d      = HOLD;
                move_valid_d = 1'b1;
                move_cell_d  = cand_q;
              end
            end else begin
              cand_d = hover_cell_q;
              cnt_d  = 8'd1;
            end
          end
        end
        HOLD: begin
          // An ack coinciding with a frame tick takes priority; that frame is dropped.
          if (iMOVE_ACK) begin
            state_d      = LOCKOUT;
            move_valid_d = 1'b0;
            rel_d        = 8'd0;
            cnt_d        = 8'd0;
          end
        end
        LOCKOUT: begin
          if (tick_q) begin
            if (!hover_valid_q || hover_cell_q != move_cell_q) begin
              rel_d = rel_q + 8'd1;
              if (rel_q + 8'd1 == REL_C) begin
                state_d = IDLE;
                rel_d   = 8'd0;
                cnt_d   = 8'd0;
              end
            end else begin
              rel_d = 8'd0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign oMOVE_VALID  = move_valid_q;
  assign oMOVE_CELL   = move_cell_q;
  assign oHOVER_CELL  = hover_cell_q;
  assign oHOVER_VALID = hover_valid_q;
  assign oDWELL_CNT   = (cnt_q > 8'd15) ? 4'hF : cnt_q[3:0];
  assign oSTATE       = state_q;

endmodule

// File: tb/tb_ft_cell_selector.sv
// Directed bench for ft_cell_selector: dwell commit, candidate switch, hold/ack,
// lockout release, grid boundaries, enable drop and asynchronous reset.
module tb_ft_cell_selector;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iEN = 1'b1;
  logic [9:0] iFT_X = 10'd0;
  logic [9:0] iFT_Y = 10'd0;
  logic       iFT_VAL = 1'b0;
  logic       iMOVE_ACK = 1'b0;
  logic       oMOVE_VALID;
  logic [3:0] oMOVE_CELL;
  logic [3:0] oHOVER_CELL;
  logic       oHOVER_VALID;
  logic [3:0] oDWELL_CNT;
  logic [1:0] oSTATE;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_TRACK = 2'd1, S_HOLD = 2'd2, S_LOCK = 2'd3;

  ft_cell_selector dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN),
    .iFT_X(iFT_X), .iFT_Y(iFT_Y), .iFT_VAL(iFT_VAL), .iMOVE_ACK(iMOVE_ACK),
    .oMOVE_VALID(oMOVE_VALID), .oMOVE_CELL(oMOVE_CELL),
    .oHOVER_CELL(oHOVER_CELL), .oHOVER_VALID(oHOVER_VALID),
    .oDWELL_CNT(oDWELL_CNT), .oSTATE(oSTATE)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one frame pulse; returns after the mapping edge, before the FSM edge.
  task automatic drive_frame(input int x, input int y);
    @(negedge iCLK);
    iFT_X   = 10'(x);
    iFT_Y   = 10'(y);
    iFT_VAL = 1'b1;
    @(negedge iCLK);
    iFT_VAL = 1'b0;
  endtask

  task automatic step();
    @(negedge iCLK);
  endtask

  task automatic frame(input int x, input int y);
    drive_frame(x, y);
    step();
  endtask

  task automatic ack_pulse();
    @(negedge iCLK);
    iMOVE_ACK = 1'b1;
    @(negedge iCLK);
    iMOVE_ACK = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mv"}, 32'(oMOVE_VALID), 32'd0);
    check({tag, "_mc"}, 32'(oMOVE_CELL), 32'd0);
    check({tag, "_hc"}, 32'(oHOVER_CELL), 32'hF);
    check({tag, "_hv"}, 32'(oHOVER_VALID), 32'd0);
    check({tag, "_dc"}, 32'(oDWELL_CNT), 32'd0);
    check({tag, "_st"}, 32'(oSTATE), 32'(S_IDLE));
  endtask

  initial begin
    int xs[6];
    int ys[6];
    logic [3:0] cells[6];
    xs    = '{212, 213, 425, 426, 639, 640};
    ys    = '{159, 160, 319, 320, 479, 480};
    repeat (3) @(negedge iCLK);
    check_reset_outputs("rst");
    iRST = 1'b1;

    // First move on cell 4
    drive_frame(300, 200);
    check("t1_hover_cell", 32'(oHOVER_CELL), 32'd4);
    check("t1_hover_valid", 32'(oHOVER_VALID), 32'd1);
    check("t1_mv_early", 32'(oMOVE_VALID), 32'd0);
    step();
    check("t1_dwell1", 32'(oDWELL_CNT), 32'd1);
    check("t1_state", 32'(oSTATE), 32'(S_TRACK));
    for (int i = 2; i <= 7; i++) begin
      frame(300, 200);
      check("t1_mv_low", 32'(oMOVE_VALID), 32'd0);
      check("t1_dwell", 32'(oDWELL_CNT), 32'(i));
    end
    drive_frame(300, 200);
    check("t1_mv_1cyc", 32'(oMOVE_VALID), 32'd0);
    step();
    check("t1_mv", 32'(oMOVE_VALID), 32'd1);
    check("t1_mc", 32'(oMOVE_CELL), 32'd4);
    check("t1_dwell8", 32'(oDWELL_CNT), 32'd8);
    check("t1_hold", 32'(oSTATE), 32'(S_HOLD));
    ack_pulse();
    check("t1_ack_mv", 32'(oMOVE_VALID), 32'd0);
    check("t1_ack_st", 32'(oSTATE), 32'(S_LOCK));
    check("t1_ack_dc", 32'(oDWELL_CNT), 32'd0);
    repeat (3) frame(1023, 1023);
    check("t1_rel3", 32'(oSTATE), 32'(S_LOCK));
    frame(1023, 1023);
    check("t1_rel4", 32'(oSTATE), 32'(S_IDLE));

    // Candidate switch from cell 0 to cell 8
    repeat (5) frame(100, 100);
    check("t2_dwell5", 32'(oDWELL_CNT), 32'd5);
    frame(500, 400);
    check("t2_switch_dc", 32'(oDWELL_CNT), 32'd1);
    check("t2_switch_st", 32'(oSTATE), 32'(S_TRACK));
    repeat (6) frame(500, 400);
    check("t2_mv_low", 32'(oMOVE_VALID), 32'd0);
    check("t2_dwell7", 32'(oDWELL_CNT), 32'd7);
    frame(500, 400);
    check("t2_mv", 32'(oMOVE_VALID), 32'd1);
    check("t2_mc", 32'(oMOVE_CELL), 32'd8);

    // Hold without ack, then ack landing on a frame tick
    for (int i = 0; i < 20; i++) begin
      frame((i % 2) ? 100 : 600, 100);
      check("t3_hold_mv", 32'(oMOVE_VALID), 32'd1);
      check("t3_hold_mc", 32'(oMOVE_CELL), 32'd8);
    end
    @(negedge iCLK);
    iFT_X = 10'd100; iFT_Y = 10'd100; iFT_VAL = 1'b1;
    @(negedge iCLK);
    iFT_VAL = 1'b0; iMOVE_ACK = 1'b1;
    @(negedge iCLK);
    iMOVE_ACK = 1'b0;
    check("t3_ack_mv", 32'(oMOVE_VALID), 32'd0);
    check("t3_ack_st", 32'(oSTATE), 32'(S_LOCK));
    repeat (3) frame(1023, 1023);
    check("t3_discard", 32'(oSTATE), 32'(S_LOCK));
    frame(1023, 1023);
    check("t3_rearm", 32'(oSTATE), 32'(S_IDLE));

    // Lockout on cell 4 with an interrupted release
    repeat (8) frame(300, 200);
    check("t4_mv", 32'(oMOVE_VALID), 32'd1);
    check("t4_mc", 32'(oMOVE_CELL), 32'd4);
    ack_pulse();
    check("t4_lock", 32'(oSTATE), 32'(S_LOCK));
    repeat (3) frame(1023, 1023);
    frame(300, 200);
    repeat (3) frame(1023, 1023);
    check("t4_no_rearm", 32'(oSTATE), 32'(S_LOCK));
    frame(1023, 1023);
    check("t4_rearm", 32'(oSTATE), 32'(S_IDLE));
    check("t4_rearm_dc", 32'(oDWELL_CNT), 32'd0);
    repeat (7) frame(300, 200);
    check("t4_mv_low", 32'(oMOVE_VALID), 32'd0);
    frame(300, 200);
    check("t4_mv2", 32'(oMOVE_VALID), 32'd1);
    check("t4_mc2", 32'(oMOVE_CELL), 32'd4);

    // Grid boundaries (FSM in HOLD ignores these frames)
    cells = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'hF};
    foreach (cells[i]) exp_q.push_back(cells[i]);
    cells = '{4'd0, 4'd3, 4'd3, 4'd6, 4'd6, 4'hF};
    foreach (cells[i]) exp_q.push_back(cells[i]);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] e;
      if (i < 6) drive_frame(xs[i], 0);
      else       drive_frame(0, ys[i-6]);
      e = exp_q.pop_front();
      check("bnd_cell", 32'(oHOVER_CELL), 32'(e));
      check("bnd_valid", 32'(oHOVER_VALID), (e == 4'hF) ? 32'd0 : 32'd1);
    end
    step();
    check("bnd_hold_mv", 32'(oMOVE_VALID), 32'd1);
    check("bnd_hold_mc", 32'(oMOVE_CELL), 32'd4);

    // Enable drop in HOLD
    @(negedge iCLK);
    iEN = 1'b0;
    @(negedge iCLK);
    check("en_mv", 32'(oMOVE_VALID), 32'd0);
    check("en_st", 32'(oSTATE), 32'(S_IDLE));
    check("en_dc", 32'(oDWELL_CNT), 32'd0);
    iEN = 1'b1;

    // Asynchronous reset mid-TRACK and in HOLD
    repeat (6) frame(300, 200);
    check("rt_dwell6", 32'(oDWELL_CNT), 32'd6);
    @(posedge iCLK);
    #3 iRST = 1'b0;
    #1 check_reset_outputs("rst_track");
    @(negedge iCLK);
    iRST = 1'b1;
    repeat (8) frame(300, 200);
    check("rh_hold", 32'(oSTATE), 32'(S_HOLD));
    #2 iRST = 1'b0;
    #1 check_reset_outputs("rst_hold");
    @(negedge iCLK);
    iRST = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
